z_encoder4to2: RTL and testbench

Sequential 4-to-2 encoder that is the inverse of the team's 2-to-4 decoder (`test3`, inputs `A`, `B`, `En`, output `Z[3:0]`). It captures a 4-bit line vector `Z` and emits the 2-bit index `{A,B}` of every asserted line, one index per accepted handshake, in priority order. Each emitted index, fed back into the decoder, reproduces exactly one of the captured lines. It sits between request/line sources and the decoder's select inputs.

---
 rtl/z_encoder4to2_if.sv | 15 +
 rtl/z_encoder4to2.sv | 50 +++++
 tb/tb_z_encoder4to2.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/z_encoder4to2_if.sv
// z_encoder4to2_if: line-vector capture and index handshake bundle for z_encoder4to2
//   master drives En, load, Z, ready; slave drives A, B, valid, busy, none
interface z_encoder4to2_if;
   logic       En;
   logic       load;
   logic [3:0] Z;
   logic       ready;
   logic       A;
   logic       B;
   logic       valid;
   logic       busy;
   logic       none;
   modport master (output En, load, Z, ready, input A, B, valid, busy, none);
   modport slave  (input En, load, Z, ready, output A, B, valid, busy, none);
endinterface

// File: rtl/z_encoder4to2.sv
// z_encoder4to2: captures a 4-bit line vector and emits the {A,B} index of each set line, one per handshake
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of z_encoder4to2_if (En, load, Z, ready in; A, B, valid, busy, none out)
//   PRIORITY_HIGH : 0 emits lowest set line first, 1 emits highest first
module z_encoder4to2 #(
   parameter bit PRIORITY_HIGH = 1'b0
) (
   input logic            clk,
   input logic            rst_n,
   z_encoder4to2_if.slave bus
);
   typedef enum logic {IDLE, SCAN} state_e;
   state_e     state_q;
   logic [3:0] pend_q, pend_d;
   logic       none_q;
   logic [1:0] idx;
   logic       hs;
   always_comb begin
      idx = PRIORITY_HIGH ?
            (pend_q[3] ? 2'd3 : pend_q[2] ? 2'd2 : pend_q[1] ? 2'd1 : 2'd0) :
            (pend_q[0] ? 2'd0 : pend_q[1] ? 2'd1 : pend_q[2] ? 2'd2 : 2'd3);
      hs     = (state_q == SCAN) && bus.En && bus.ready;
      pend_d = pend_q & ~(4'b0001 << idx);
   end
   // index follows the frozen pend register, so it holds while En is low
   assign bus.valid = (state_q == SCAN) && bus.En;
   assign bus.busy  = state_q == SCAN;
   assign bus.A     = (state_q == SCAN) && idx[1];
   assign bus.B     = (state_q == SCAN) && idx[0];
   assign bus.none  = none_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pend_q  <= 4'b0000;
         none_q  <= 1'b0;
      end else begin
         none_q <= (state_q == IDLE) && bus.load && bus.En && (bus.Z == 4'b0000);
         if (state_q == IDLE) begin
            if (bus.load && bus.En) begin
               pend_q  <= bus.Z;
               state_q <= (bus.Z == 4'b0000) ? IDLE : SCAN;
            end
         end else if (hs) begin
            pend_q  <= pend_d;
            state_q <= (pend_d == 4'b0000) ? IDLE : SCAN;
         end
      end
   end
endmodule

// File: tb/tb_z_encoder4to2.sv
// tb_z_encoder4to2: directed vector bench for z_encoder4to2 in both priority orders
module tb_z_encoder4to2;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0, load = 1'b0, ready = 1'b0;
   logic [3:0] z = 4'b0000;
   int pass = 0, total = 0;

   z_encoder4to2_if b0 ();
   z_encoder4to2_if b1 ();
   assign b0.En = en;    assign b1.En = en;
   assign b0.load = load; assign b1.load = load;
   assign b0.Z = z;      assign b1.Z = z;
   assign b0.ready = ready; assign b1.ready = ready;

   z_encoder4to2 #(.PRIORITY_HIGH(1'b0)) dut_lo (.clk(clk), .rst_n(rst_n), .bus(b0));
   z_encoder4to2 #(.PRIORITY_HIGH(1'b1)) dut_hi (.clk(clk), .rst_n(rst_n), .bus(b1));

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] z;
      int         n;
      logic [7:0] lo;
      logic [7:0] hi;
   } vec_t;
   vec_t vecs[6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else pass++;
   endtask

   function automatic logic [3:0] dec(input logic a, input logic b, input logic e);
      return e ? (4'b0001 << {a, b}) : 4'b0000;
   endfunction

   task automatic idle_chk(input string name);
      chk({name, " busy_lo"}, 8'(b0.busy), 8'd0);
      chk({name, " busy_hi"}, 8'(b1.busy), 8'd0);
      chk({name, " valid_lo"}, 8'(b0.valid), 8'd0);
      chk({name, " ab_lo"}, 8'({b0.A, b0.B}), 8'd0);
      chk({name, " ab_hi"}, 8'({b1.A, b1.B}), 8'd0);
   endtask

   initial begin
      logic [3:0] acc0, acc1;
      vecs[0] = '{4'b0100, 1, 8'h02, 8'h02};
      vecs[1] = '{4'b1011, 3, 8'h34, 8'h07};
      vecs[2] = '{4'b0110, 2, 8'h09, 8'h06};
      vecs[3] = '{4'b1111, 4, 8'hE4, 8'h1B};
      vecs[4] = '{4'b1000, 1, 8'h03, 8'h03};
      vecs[5] = '{4'b0001, 1, 8'h00, 8'h00};
      #2;
      idle_chk("reset");
      chk("reset none", 8'(b0.none), 8'd0);
      tick();
      rst_n = 1'b1;
      en = 1'b1;
      tick();
      foreach (vecs[v]) begin
         load = 1'b1; z = vecs[v].z; ready = 1'b1;
         tick();
         load = 1'b0; z = 4'b0000;
         for (int i = 0; i < vecs[v].n; i++) begin
            chk($sformatf("v%0d[%0d] valid_lo", v, i), 8'(b0.valid), 8'd1);
            chk($sformatf("v%0d[%0d] valid_hi", v, i), 8'(b1.valid), 8'd1);
            chk($sformatf("v%0d[%0d] busy_lo", v, i), 8'(b0.busy), 8'd1);
            chk($sformatf("v%0d[%0d] ab_lo", v, i), 8'({b0.A, b0.B}), 8'(vecs[v].lo[2*i +: 2]));
            chk($sformatf("v%0d[%0d] ab_hi", v, i), 8'({b1.A, b1.B}), 8'(vecs[v].hi[2*i +: 2]));
            tick();
         end
         idle_chk($sformatf("v%0d done", v));
      end
      load = 1'b1; z = 4'b0000;
      tick();
      load = 1'b0;
      chk("zero none", 8'(b0.none), 8'd1);
      chk("zero valid", 8'(b0.valid), 8'd0);
      chk("zero busy", 8'(b0.busy), 8'd0);
      tick();
      chk("zero none end", 8'(b0.none), 8'd0);
      chk("zero valid end", 8'(b0.valid), 8'd0);
      chk("zero busy end", 8'(b0.busy), 8'd0);
      load = 1'b1; z = 4'b0110; ready = 1'b0;
      tick();
      load = 1'b1; z = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("stall%0d valid", i), 8'(b0.valid), 8'd1);
         chk($sformatf("stall%0d ab_lo", i), 8'({b0.A, b0.B}), 8'd1);
         chk($sformatf("stall%0d ab_hi", i), 8'({b1.A, b1.B}), 8'd2);
         tick();
      end
      en = 1'b0; ready = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("freeze%0d valid", i), 8'(b0.valid), 8'd0);
         chk($sformatf("freeze%0d busy", i), 8'(b0.busy), 8'd1);
         chk($sformatf("freeze%0d ab_lo", i), 8'({b0.A, b0.B}), 8'd1);
         tick();
      end
      en = 1'b1; load = 1'b0;
      #1;
      chk("resume ab_lo", 8'({b0.A, b0.B}), 8'd1);
      chk("resume valid", 8'(b0.valid), 8'd1);
      tick();
      chk("second ab_lo", 8'({b0.A, b0.B}), 8'd2);
      chk("second ab_hi", 8'({b1.A, b1.B}), 8'd1);
      load = 1'b1; z = 4'b1000;
      tick();
      idle_chk("last hs load ignored");
      tick();
      load = 1'b0;
      chk("reload valid", 8'(b0.valid), 8'd1);
      chk("reload ab", 8'({b0.A, b0.B}), 8'd3);
      tick();
      idle_chk("reload done");
      for (int v = 0; v < 16; v++) begin
         load = 1'b1; z = 4'(v); ready = 1'b1;
         tick();
         load = 1'b0;
         acc0 = 4'b0000; acc1 = 4'b0000;
         for (int c = 0; c < 6; c++) begin
            if (b0.valid) acc0 |= dec(b0.A, b0.B, 1'b1);
            if (b1.valid) acc1 |= dec(b1.A, b1.B, 1'b1);
            tick();
         end
         chk($sformatf("decode lo z=%0d", v), 8'(acc0), 8'(v));
         chk($sformatf("decode hi z=%0d", v), 8'(acc1), 8'(v));
      end
      load = 1'b1; z = 4'b1111; ready = 1'b0;
      tick();
      load = 1'b0;
      tick();
      chk("pre-reset ab_hi", 8'({b1.A, b1.B}), 8'd3);
      #2;
      rst_n = 1'b0;
      #1;
      idle_chk("async reset");
      chk("async reset valid_hi", 8'(b1.valid), 8'd0);
      tick();
      rst_n = 1'b1;
      tick();
      idle_chk("after reset");
      load = 1'b1; z = 4'b0100; ready = 1'b1;
      tick();
      load = 1'b0;
      chk("post-reset valid", 8'(b0.valid), 8'd1);
      chk("post-reset ab", 8'({b0.A, b0.B}), 8'd2);
      tick();
      idle_chk("post-reset done");
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
